// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Each digit is lit for SCAN_DIV cycles, followed by
// GUARD_CYC dark cycles. Digit codes and blank_mask are latched once per frame.
// Optional build macro: LEADZERO_SUPPRESS_EN blanks leading zero digits
// (Digit 4 is never suppressed).
module display_scan_controller #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GUARD_CYC = 500,
  parameter int unsigned DIG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIG_W-1:0] digit1,
  input  logic [DIG_W-1:0] digit2,
  input  logic [DIG_W-1:0] digit3,
  input  logic [DIG_W-1:0] digit4,
  input  logic [3:0]       blank_mask,
  output logic [3:0]       digit_n,
  output logic [6:0]       seg_n,
  output logic             frame_start
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ON, GUARD} state_t;

  state_t             state, state_nx;
  logic [1:0]         idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               load;
  logic [DIG_W-1:0]   shd [4];
  logic [DIG_W-1:0]   shd_nx [4];
  logic [3:0]         sblank, sblank_nx;
  logic [3:0]         eff_blank;
  logic [3:0]         digit_n_nx;
  logic [6:0]         seg_n_nx;

  function automatic logic [6:0] decode(input logic [DIG_W-1:0] code);
    case (code)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Effective blank captured at each shadow load
  always_comb begin
    eff_blank = blank_mask;
`ifdef LEADZERO_SUPPRESS_EN
    eff_blank[3] = blank_mask[3] | (digit1 == '0);
    eff_blank[2] = blank_mask[2] | ((digit1 == '0) && (digit2 == '0));
    eff_blank[1] = blank_mask[1] | ((digit1 == '0) && (digit2 == '0) && (digit3 == '0));
`endif
  end

  // Next-state, shadow load and next registered outputs
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = ON;
          idx_nx   = '0;
          cnt_nx   = '0;
          load     = 1'b1;
        end
      end
      ON: begin
        if (cnt == CNT_W'(SCAN_DIV - 1)) begin
          state_nx = GUARD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GUARD: begin
        if (cnt == CNT_W'(GUARD_CYC - 1)) begin
          state_nx = ON;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          load     = (idx == 2'd3);
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
      load     = 1'b0;
    end

    shd_nx[0] = load ? digit1 : shd[0];
    shd_nx[1] = load ? digit2 : shd[1];
    shd_nx[2] = load ? digit3 : shd[2];
    shd_nx[3] = load ? digit4 : shd[3];
    sblank_nx = load ? eff_blank : sblank;

    // Outputs are derived from the incoming state so they are lit in the
    // same cycle the FSM enters ON (including freshly loaded shadows).
    digit_n_nx = '1;
    seg_n_nx   = '1;
    if (state_nx == ON) begin
      seg_n_nx = decode(shd_nx[idx_nx]);
      if (!sblank_nx[2'd3 - idx_nx]) digit_n_nx[2'd3 - idx_nx] = 1'b0;
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      for (int unsigned i = 0; i < 4; i++) shd[i] <= '0;
      sblank      <= '1;
      digit_n     <= '1;
      seg_n       <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      for (int unsigned i = 0; i < 4; i++) shd[i] <= shd_nx[i];
      sblank      <= sblank_nx;
      digit_n     <= digit_n_nx;
      seg_n       <= seg_n_nx;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller: directed phases plus random stimulus,
// checked every cycle against a frame-time reference model.
module tb_display_scan_controller;

  localparam int S  = 4;
  localparam int G  = 2;
  localparam int FR = 4 * (S + G);

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] digit1, digit2, digit3, digit4, blank_mask;
  logic [3:0] digit_n;
  logic [6:0] seg_n;
  logic       frame_start;

  int checks = 0;
  int failures = 0;
  bit active = 0;

  display_scan_controller #(.SCAN_DIV(S), .GUARD_CYC(G)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .blank_mask(blank_mask), .digit_n(digit_n), .seg_n(seg_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: time since frame start plus values captured at frame start
  bit         run = 0;
  int         t = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_blank;

  always @(posedge clk) begin
    if (reset || !enable) begin
      run = 0;
      t = 0;
    end else if (!run || t == FR - 1) begin
      run = 1;
      t = 0;
      m_dig[0] = digit1; m_dig[1] = digit2; m_dig[2] = digit3; m_dig[3] = digit4;
      m_blank = blank_mask;
`ifdef LEADZERO_SUPPRESS_EN
      if (digit1 == 0) m_blank[3] = 1'b1;
      if (digit1 == 0 && digit2 == 0) m_blank[2] = 1'b1;
      if (digit1 == 0 && digit2 == 0 && digit3 == 0) m_blank[1] = 1'b1;
`endif
    end else begin
      t = t + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (active) begin
      logic [3:0] e_dn;
      logic [6:0] e_seg;
      logic       e_fs;
      int slot, w;
      e_dn = 4'b1111; e_seg = 7'b1111111; e_fs = 1'b0;
      if (run) begin
        slot = t / (S + G);
        w    = t % (S + G);
        e_fs = (t == 0);
        if (w < S) begin
          e_seg = seg_tab[m_dig[slot]];
          if (!m_blank[3 - slot]) e_dn[3 - slot] = 1'b0;
        end
      end
      check("digit_n", {4'b0, digit_n}, {4'b0, e_dn});
      check("seg_n", {1'b0, seg_n}, {1'b0, e_seg});
      check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    bit hit = 0;
    for (int i = 0; i < 4 * FR && !hit; i++) begin
      @(negedge clk);
      if (run && t == target) hit = 1;
    end
    if (!hit) begin
      failures++;
      $display("FAIL wait_t target=%0d got=timeout exp=reached", target);
    end
  endtask

  initial begin
    reset = 1; enable = 1;
    digit1 = 1; digit2 = 2; digit3 = 3; digit4 = 4; blank_mask = 0;
    @(posedge clk);
    @(negedge clk);
    active = 1;
    step(1);
    reset = 0;
    // Basic scan order/timing over several frames
    step(3 * FR);

    // Frame coherency: digit2 changes while Digit 1 is lit
    digit2 = 5;
    wait_t(0);
    wait_t(1);
    digit2 = 8;
    step(2 * FR);

    // Blank Digit 2, then drop enable mid-ON and re-enable
    blank_mask = 4'b0100;
    wait_t(0);
    step(FR);
    wait_t(S + G + 1);
    enable = 0;
    step(3);
    blank_mask = 0;
    enable = 1;
    step(FR);

    // Decode sweep through Digit 4
    for (int v = 0; v < 16; v++) begin
      digit4 = 4'(v);
      wait_t(0);
      step(FR - 1);
    end

    // Leading-zero pattern (dark for Digits 1/2 only when suppression is built in)
    digit1 = 0; digit2 = 0; digit3 = 7; digit4 = 0;
    wait_t(0);
    step(2 * FR);

    // Mid-scan reset
    wait_t(7);
    reset = 1;
    step(2);
    reset = 0;
    step(FR);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digit1 = 4'($urandom); digit2 = 4'($urandom);
        digit3 = 4'($urandom); digit4 = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 0;
    enable = 1;
    step(FR);

    active = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
